// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word loader and its 8N1 receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int ADDR_W    = 13;
  localparam int WORD_W    = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, LSB-first shift register.
// Exposes rx_busy only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_HZ   = 25000000,
  parameter int BAUDRATE = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 rx_ferr
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic                 rx_busy
`endif
);

  localparam int DIV   = CLK_HZ / BAUDRATE;
  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  logic [1:0]           sync_q;
  rx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_s;

  assign rx_s = sync_q[1];

`ifdef UART_RX_TIMEOUT_EN
  assign rx_busy = (state_q != IDLE);
`endif

  // Synchronizer, receive FSM and one-cycle result strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx_i};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (rx_s) begin
              rx_byte  <= shift_q;
              rx_valid <= 1'b1;
              state_q  <= IDLE;
            end else begin
              rx_ferr <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        WAIT_HIGH: begin
          // A break holds the line low; stay here so it yields a single frame error.
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_word_loader.sv
// Packs received UART bytes little-endian into 32-bit words and emits a write strobe per word.
// Optional inter-byte timeout that drops a partial word: define UART_RX_TIMEOUT_EN.
module uart_word_loader
  import uart_pkg::*;
#(
  parameter int CLK_HZ        = 25000000,
  parameter int BAUDRATE      = 9600,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  output logic              WE,
  output logic [ADDR_W-1:0] WA,
  output logic [WORD_W-1:0] WD,
  output logic              frame_err
);

  logic [DATA_BITS-1:0]        rx_byte_s;
  logic                        rx_valid_s;
  logic                        rx_ferr_s;
  logic                        timeout_s;

  logic [1:0]                  lane_q, lane_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [WORD_W-DATA_BITS-1:0] buf_q, buf_d;
  logic [WORD_W-1:0]           wd_q, wd_d;
  logic [ADDR_W-1:0]           wa_q, wa_d;
  logic                        we_q, we_d;
  logic                        ferr_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BYTES * 10 * (CLK_HZ / BAUDRATE);
  localparam int TO_W   = $clog2(TO_CYC) + 1;

  logic            rx_busy_s;
  logic [TO_W-1:0] to_q, to_d;

  assign timeout_s = (lane_q != 2'd0) && !rx_busy_s && (to_q == TO_W'(TO_CYC - 1));

  // Idle-time counter, armed only while a partial word is pending and no byte is in flight.
  always_comb begin
    to_d = to_q;
    if (lane_q == 2'd0 || rx_busy_s || rx_valid_s || timeout_s) begin
      to_d = '0;
    end else begin
      to_d = to_q + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`else
  assign timeout_s = 1'b0;
`endif

  uart_rx_8n1 #(
    .CLK_HZ   (CLK_HZ),
    .BAUDRATE (BAUDRATE)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (RX),
    .rx_byte  (rx_byte_s),
    .rx_valid (rx_valid_s),
    .rx_ferr  (rx_ferr_s)
`ifdef UART_RX_TIMEOUT_EN
    ,
    .rx_busy  (rx_busy_s)
`endif
  );

  // Lane/address bookkeeping; frame errors never reach here, so a partial word survives them.
  always_comb begin
    lane_d = lane_q;
    addr_d = addr_q;
    buf_d  = buf_q;
    wd_d   = wd_q;
    wa_d   = wa_q;
    we_d   = 1'b0;
    if (rx_valid_s) begin
      if (lane_q == 2'd3) begin
        we_d   = 1'b1;
        wa_d   = addr_q;
        wd_d   = {rx_byte_s, buf_q};
        addr_d = addr_q + 13'd1;
        lane_d = 2'd0;
        buf_d  = '0;
      end else begin
        case (lane_q)
          2'd0:    buf_d[7:0]   = rx_byte_s;
          2'd1:    buf_d[15:8]  = rx_byte_s;
          2'd2:    buf_d[23:16] = rx_byte_s;
          default: buf_d        = buf_q;
        endcase
        lane_d = lane_q + 2'd1;
      end
    end else if (timeout_s) begin
      lane_d = 2'd0;
      buf_d  = '0;
    end else begin
      lane_d = lane_q;
    end
  end

  // Word assembly state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= 2'd0;
      addr_q <= '0;
      buf_q  <= '0;
      wd_q   <= '0;
      wa_q   <= '0;
      we_q   <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      addr_q <= addr_d;
      buf_q  <= buf_d;
      wd_q   <= wd_d;
      wa_q   <= wa_d;
      we_q   <= we_d;
      ferr_q <= rx_ferr_s;
    end
  end

  assign WE        = we_q;
  assign WA        = wa_q;
  assign WD        = wd_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Randomized self-checking bench for uart_word_loader (DIV = 16); honours UART_RX_TIMEOUT_EN.
module tb_uart_word_loader;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX  = 1'b1;
  logic        WE;
  logic [12:0] WA;
  logic [31:0] WD;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;

  // Reference model state: pending bytes of the current word and the next write address.
  logic [7:0]  pend[$];
  int          m_addr = 0;
  logic [12:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [12:0] mon_wa[$];
  logic [31:0] mon_wd[$];

  uart_word_loader #(
    .CLK_HZ        (160),
    .BAUDRATE      (10),
    .TIMEOUT_BYTES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Record every write strobe and frame error seen by the outside world.
  always @(negedge clk) begin
    if (!rst) begin
      if (WE === 1'b1) begin
        mon_wa.push_back(WA);
        mon_wd.push_back(WD);
      end
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  function automatic void model_byte(input logic [7:0] b);
    pend.push_back(b);
    if (pend.size() == 4) begin
      exp_wa.push_back(13'(m_addr));
      exp_wd.push_back({pend[3], pend[2], pend[1], pend[0]});
      m_addr = (m_addr + 1) % 8192;
      pend.delete();
    end
  endfunction

  function automatic void model_reset();
    pend.delete();
    m_addr = 0;
  endfunction

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (DIV) @(negedge clk);
    end
    RX = stop_bit;
    repeat (DIV) @(negedge clk);
    RX = 1'b1;
    if (stop_bit) model_byte(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    RX  = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (WE !== 1'b0 || frame_err !== 1'b0 || WA !== 13'd0 || WD !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got WE=%b ferr=%b WA=%0d WD=%h, expected 0 0 0 00000000",
               WE, frame_err, WA, WD);
    end
    rst = 1'b0;
    model_reset();
    idle(40);
    n_checks++;
    if (mon_wa.size() != 0 || ferr_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d writes %0d frame errors, expected 0 0", mon_wa.size(), ferr_cnt);
    end
  endtask

  task automatic test_basic();
    logic [7:0] seq [8];
    seq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b1);
    idle(30);
    n_checks++;
    if (WA !== 13'd0 || WD !== 32'h12345678) begin
      n_fail++;
      $display("FAIL basic_word0: got WA=%0d WD=%h, expected WA=0 WD=12345678", WA, WD);
    end
    n_checks++;
    if (WE !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_we_idle: got WE=%b, expected 0", WE);
    end
    for (int i = 4; i < 8; i++) send_byte(seq[i], 1'b1);
    idle(60);
    n_checks++;
    if (WA !== 13'd1 || WD !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_word1_held: got WA=%0d WD=%h, expected WA=1 WD=deadbeef", WA, WD);
    end
    n_checks++;
    if (mon_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d writes, expected %0d", mon_wa.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      n_checks++;
      if (mon_wa[i] !== exp_wa[i] || mon_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d: got WA=%0d WD=%h, expected WA=%0d WD=%h",
                 i, mon_wa[i], mon_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
    mon_wa.delete(); mon_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic test_false_start();
    int f0;
    f0 = ferr_cnt;
    RX = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    n_checks++;
    if (ferr_cnt != f0 || mon_wa.size() != 0) begin
      n_fail++;
      $display("FAIL false_start_quiet: got %0d frame errors %0d writes, expected 0 0",
               ferr_cnt - f0, mon_wa.size());
    end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(30);
    n_checks++;
    if (mon_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL false_start_count: got %0d writes, expected %0d", mon_wa.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      n_checks++;
      if (mon_wa[i] !== exp_wa[i] || mon_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL false_start_write%0d: got WA=%0d WD=%h, expected WA=%0d WD=%h",
                 i, mon_wa[i], mon_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
    mon_wa.delete(); mon_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_cnt;
    for (int i = 0; i < 2; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'hA5, 1'b0);
    RX = 1'b0;
    repeat (100) @(negedge clk);
    idle(30);
    n_checks++;
    if (ferr_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL frame_err_pulses: got %0d, expected 1", ferr_cnt - f0);
    end
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(30);
    n_checks++;
    if (mon_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL frame_err_count: got %0d writes, expected %0d", mon_wa.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      n_checks++;
      if (mon_wa[i] !== exp_wa[i] || mon_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL frame_err_write%0d: got WA=%0d WD=%h, expected WA=%0d WD=%h",
                 i, mon_wa[i], mon_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
    mon_wa.delete(); mon_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      idle($urandom_range(0, 30));
    end
    idle(30);
    n_checks++;
    if (mon_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d writes, expected %0d", mon_wa.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      n_checks++;
      if (mon_wa[i] !== exp_wa[i] || mon_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL random_write%0d: got WA=%0d WD=%h, expected WA=%0d WD=%h",
                 i, mon_wa[i], mon_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
    mon_wa.delete(); mon_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic test_addr_wrap();
    force dut.addr_q = 13'd8191;
    @(negedge clk);
    @(negedge clk);
    release dut.addr_q;
    m_addr = 8191;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(30);
    n_checks++;
    if (mon_wa.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d writes, expected 2", mon_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      n_checks++;
      if (mon_wa[i] !== exp_wa[i] || mon_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL wrap_write%0d: got WA=%0d WD=%h, expected WA=%0d WD=%h",
                 i, mon_wa[i], mon_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
    mon_wa.delete(); mon_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic test_timeout();
    int f0;
    f0 = ferr_cnt;
    for (int i = 0; i < 2; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(700);
`ifdef UART_RX_TIMEOUT_EN
    pend.delete();
`endif
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    while (pend.size() != 0) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(30);
    n_checks++;
    if (ferr_cnt != f0 || mon_wa.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL timeout_count: got %0d writes %0d frame errors, expected %0d 0",
               mon_wa.size(), ferr_cnt - f0, exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      n_checks++;
      if (mon_wa[i] !== exp_wa[i] || mon_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL timeout_write%0d: got WA=%0d WD=%h, expected WA=%0d WD=%h",
                 i, mon_wa[i], mon_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
    mon_wa.delete(); mon_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    b = 8'h2C;
    for (int i = 0; i < 2; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    RX = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      repeat (DIV) @(negedge clk);
    end
    RX = b[4];
    repeat (DIV / 2) @(negedge clk);
    rst = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (WE !== 1'b0 || WA !== 13'd0 || WD !== 32'd0) begin
      n_fail++;
      $display("FAIL midbyte_reset_outputs: got WE=%b WA=%0d WD=%h, expected 0 0 00000000", WE, WA, WD);
    end
    rst = 1'b0;
    model_reset();
    idle(60);
    n_checks++;
    if (mon_wa.size() != 0) begin
      n_fail++;
      $display("FAIL midbyte_no_write: got %0d writes, expected 0", mon_wa.size());
    end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(30);
    n_checks++;
    if (mon_wa.size() != 1) begin
      n_fail++;
      $display("FAIL midbyte_count: got %0d writes, expected 1", mon_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      n_checks++;
      if (mon_wa[i] !== exp_wa[i] || mon_wd[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL midbyte_write%0d: got WA=%0d WD=%h, expected WA=%0d WD=%h",
                 i, mon_wa[i], mon_wd[i], exp_wa[i], exp_wd[i]);
      end
    end
    mon_wa.delete(); mon_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_random();
    test_addr_wrap();
    test_timeout();
    test_reset_mid_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
- REQ-001: Parameter CLK_HZ, default 25000000, system clock frequency in Hz.
- REQ-002: Parameter BAUDRATE, default 9600, serial bit rate.
- REQ-003: Parameter TIMEOUT_BYTES, default 4, inter-byte timeout in byte times; used only with UART_RX_TIMEOUT_EN.
- REQ-004: clk  input  1  system clock; all logic on posedge clk.
- REQ-005: rst  input  1  reset, synchronous, active-high.
- REQ-006: RX  input  1  asynchronous UART receive line, idle high.
- REQ-007: WE  output  1  one-cycle write strobe for a completed word.
- REQ-008: WA  output  13  word address of the write, valid while WE=1.
- REQ-009: WD  output  32  assembled word, valid while WE=1.
- REQ-010: frame_err  output  1  one-cycle pulse on a bad stop bit.

Function
- REQ-011: RX SHALL pass through a 2-flop synchronizer before any use; the synchronizer adds 2 cycles of input latency.
- REQ-012: Bit period DIV = CLK_HZ/BAUDRATE (integer division); the counter width SHALL be $clog2(DIV)+1.
- REQ-013: Receiver FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
- REQ-014: IDLE -> START when the synchronized RX is 0.
- REQ-015: START waits DIV/2 cycles, then re-samples RX; 1 = false start -> IDLE, 0 -> DATA.
- REQ-016: DATA samples RX every DIV cycles, 8 samples, LSB first, into a shift register.
- REQ-017: STOP samples RX after DIV cycles; 1 = byte valid -> IDLE; 0 = pulse frame_err, discard the byte -> WAIT_HIGH.
- REQ-018: WAIT_HIGH -> IDLE only once the synchronized RX is 1; a held-low (break) line SHALL produce only one frame_err.
- REQ-019: Valid bytes fill a 2-bit lane counter little-endian: lane0 -> WD[7:0], lane1 -> [15:8], lane2 -> [23:16], lane3 -> [31:24].
- REQ-020: On the lane3 byte, WE SHALL assert exactly one cycle, in the cycle after the stop-bit sample, with WA = current address; then the lane returns to 0 and the address increments.
- REQ-021: The address SHALL wrap from 8191 to 0 without any flag.
- REQ-022: WD SHALL hold its value after WE until overwritten; WE=0 at all other times.
- REQ-023: A frame error SHALL leave the lane counter and address unchanged; the partial word is kept.

Reset
- REQ-024: While rst=1: FSM=IDLE, WE=0, frame_err=0, WA=0, WD=0, lane=0, counters=0, synchronizer flops=1.
- REQ-025: rst asserted mid-byte SHALL abort the byte; the next start bit is detected only after rst deasserts and RX is high.

Configuration
- REQ-026: Macro UART_RX_TIMEOUT_EN. When defined: if lane!=0 and no start bit is seen for TIMEOUT_BYTES*10*DIV cycles, then lane=0 and the partial word is discarded; the address is unchanged and frame_err is not pulsed.
- REQ-027: When UART_RX_TIMEOUT_EN is undefined, no timeout counter SHALL exist and a partial word waits indefinitely.

Structure
- REQ-028: Package uart_pkg SHALL hold the FSM state enum (rx_state_t) and the constants DATA_BITS=8 and ADDR_W=13.
- REQ-029: Sub-module uart_rx_8n1 (sync, FSM, shift register; outputs rx_byte, rx_valid, rx_ferr); the word assembly, lane and address logic stay in uart_word_loader.

Verification (bench: CLK_HZ=160, BAUDRATE=10, DIV=16)
- REQ-030: Bytes 0x78,0x56,0x34,0x12 sent back-to-back -> one WE pulse, WA=0, WD=0x12345678; then 0xEF,0xBE,0xAD,0xDE -> WA=1, WD=0xDEADBEEF.
- REQ-031: RX low for 5 cycles then high -> false start: no frame_err, no state change, next byte received normally.
- REQ-032: Byte 0xA5 with stop bit 0, RX then held low 100 cycles -> one frame_err pulse, lane unchanged; the next 4 good bytes form one word.
- REQ-033: Force the address to 8191 (send 8191 words, or use a preload hook in the bench) -> the next word is written at WA=8191 and the following word at WA=0.
- REQ-034: rst pulsed during bit 4 of a byte -> no WE, WA=0; a subsequent full word is written at WA=0.
- REQ-035: With UART_RX_TIMEOUT_EN: send 2 bytes, idle 640+ cycles, send 4 bytes -> one WE with WD = the last 4 bytes; without the macro -> WD = bytes 1..4.
